// File: rtl/dnn_mac_sched.sv
// Two-layer 4-4-2 integer MLP evaluated serially on one shared signed multiplier.
// Layer 1 takes 16 cycles and layer 2 takes 8; the result is held until the consumer accepts it.
module dnn_mac_sched #(
  parameter int RELU_EN = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] x,
  input  logic [79:0] w1,
  input  logic [39:0] w2,
  output logic [16:0] out0,
  output logic [16:0] out1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int unsigned DW = 5;
  localparam int unsigned HW = 12;
  localparam int unsigned AW = 17;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_L1   = 2'd1;
  localparam logic [1:0] S_L2   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [3:0]  k, k_nxt;
  logic        capture, mac_l1, mac_l2, load_out, release_out;

  logic [19:0] x_r;
  logic [79:0] w1_r;
  logic [39:0] w2_r;

  logic signed [DW-1:0] x_a  [4];
  logic signed [DW-1:0] w1_a [16];
  logic signed [DW-1:0] w2_a [8];
  logic signed [HW-1:0] h    [4];
  logic signed [HW-1:0] h_use[4];
  logic signed [AW-1:0] a    [2];

  logic signed [HW-1:0] mul_a;
  logic signed [DW-1:0] mul_b;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] a_sum;

  // Unpack captured operands; hidden values pass through the optional ReLU.
  always_comb begin
    for (int i = 0; i < 4; i++) x_a[i] = x_r[DW*i +: DW];
    for (int i = 0; i < 16; i++) w1_a[i] = w1_r[DW*i +: DW];
    for (int i = 0; i < 8; i++) w2_a[i] = w2_r[DW*i +: DW];
    for (int j = 0; j < 4; j++) h_use[j] = ((RELU_EN != 0) && h[j][HW-1]) ? '0 : h[j];
  end

  // Shared multiplier: x*w1 in layer 1, h*w2 in layer 2.
  always_comb begin
    if (state == S_L2) begin
      mul_a = h_use[k[1:0]];
      mul_b = w2_a[k[2:0]];
    end else begin
      mul_a = {{(HW-DW){x_a[k[1:0]][DW-1]}}, x_a[k[1:0]]};
      mul_b = w1_a[k];
    end
  end

  assign prod  = $signed({{(AW-HW){mul_a[HW-1]}}, mul_a}) *
                 $signed({{(AW-DW){mul_b[DW-1]}}, mul_b});
  assign a_sum = a[k[2]] + prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    capture     = 1'b0;
    mac_l1      = 1'b0;
    mac_l2      = 1'b0;
    load_out    = 1'b0;
    release_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          capture   = 1'b1;
          k_nxt     = '0;
          state_nxt = S_L1;
        end
      end
      S_L1: begin
        mac_l1 = 1'b1;
        k_nxt  = k + 4'd1;
        if (k == 4'd15) state_nxt = S_L2;
      end
      S_L2: begin
        mac_l2 = 1'b1;
        if (k == 4'd7) begin
          k_nxt     = '0;
          load_out  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          k_nxt = k + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          release_out = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, accumulators and the result/handshake flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r       <= '0;
      w1_r      <= '0;
      w2_r      <= '0;
      for (int j = 0; j < 4; j++) h[j] <= '0;
      a[0]      <= '0;
      a[1]      <= '0;
      out0      <= '0;
      out1      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (capture) begin
        x_r  <= x;
        w1_r <= w1;
        w2_r <= w2;
        for (int j = 0; j < 4; j++) h[j] <= '0;
        a[0] <= '0;
        a[1] <= '0;
      end
      if (mac_l1) h[k[3:2]] <= h[k[3:2]] + HW'(prod);
      if (mac_l2) a[k[2]] <= a_sum;
      // Load happens only at k=7, so out1 takes the final a1 update directly.
      if (load_out) begin
        out0      <= a[0];
        out1      <= a_sum;
        out_valid <= 1'b1;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
      busy     <= (state_nxt != S_IDLE);
      in_ready <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_dnn_mac_sched.sv
// Directed bench for dnn_mac_sched: one instance without and one with ReLU share stimulus.
module tb_dnn_mac_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [19:0] x;
  logic [79:0] w1;
  logic [39:0] w2;
  logic        in_ready, out_valid, busy;
  logic        r_in_ready, r_out_valid, r_busy;
  logic [16:0] out0, out1, r_out0, r_out1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dnn_mac_sched #(.RELU_EN(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w1(w1), .w2(w2), .out0(out0), .out1(out1),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  dnn_mac_sched #(.RELU_EN(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
    .x(x), .w1(w1), .w2(w2), .out0(r_out0), .out1(r_out1),
    .out_valid(r_out_valid), .out_ready(out_ready), .busy(r_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture one operand set, scramble inputs, wait for the result, optionally stall, then accept.
  task automatic run_op(input string tag, input logic [19:0] xv, input logic [79:0] w1v,
                        input logic [39:0] w2v, input logic [16:0] e0, input logic [16:0] e1,
                        input logic [16:0] r0, input logic [16:0] r1, input int hold);
    int n;
    @(negedge clk);
    x = xv; w1 = w1v; w2 = w2v; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; x = ~xv; w1 = ~w1v; w2 = ~w2v;
    check({tag, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    check({tag, " latency"}, 32'(n), 32'd24);
    check({tag, " out0"}, 32'(out0), 32'(e0));
    check({tag, " out1"}, 32'(out1), 32'(e1));
    check({tag, " relu out_valid"}, 32'(r_out_valid), 32'd1);
    check({tag, " relu out0"}, 32'(r_out0), 32'(r0));
    check({tag, " relu out1"}, 32'(r_out1), 32'(r1));
    for (int c = 0; c < hold; c++) begin
      in_valid = ~in_valid; x = ~x; w1 = ~w1;
      @(posedge clk);
      #1;
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold out0"}, 32'(out0), 32'(e0));
      check({tag, " hold out1"}, 32'(out1), 32'(e1));
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " released"}, 32'(out_valid), 32'd0);
    check({tag, " kept out0"}, 32'(out0), 32'(e0));
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " no capture"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [79:0] w1_id;
    logic [39:0] w2_mix;
    int cyc, last_cap, n_cap, n_res;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; w1 = '0; w2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out0", 32'(out0), 32'd0);
    rst_n = 1'b1;

    // All +15: hidden 900, outputs 4*900*15.
    run_op("p15", {4{5'd15}}, {16{5'd15}}, {8{5'd15}},
           17'd54000, 17'd54000, 17'd54000, 17'd54000, 0);
    // All -16: hidden 1024, outputs wrap to -65536.
    run_op("m16", {4{5'h10}}, {16{5'h10}}, {8{5'h10}},
           17'h10000, 17'h10000, 17'h10000, 17'h10000, 0);
    run_op("pos", {5'd4, 5'd3, 5'd2, 5'd1}, {16{5'd1}}, {{4{5'h1F}}, {4{5'd1}}},
           17'd40, 17'(-40), 17'd40, 17'(-40), 0);
    // Negative hidden values: ReLU instance sees zeros.
    run_op("neg", {5'd4, 5'd3, 5'd2, 5'd1}, {16{5'h1F}}, {{4{5'h1F}}, {4{5'd1}}},
           17'(-40), 17'd40, 17'd0, 17'd0, 10);

    // Identity layer 1 so h = x; out0 = 1+4+9+16, out1 = -1*1 + 5*4.
    w1_id = '0;
    for (int j = 0; j < 4; j++) w1_id[5*(5*j) +: 5] = 5'd1;
    w2_mix = {5'd5, 5'd0, 5'd0, 5'h1F, 5'd4, 5'd3, 5'd2, 5'd1};
    run_op("ident", {5'd4, 5'd3, 5'd2, 5'd1}, w1_id, w2_mix,
           17'd30, 17'd19, 17'd30, 17'd19, 0);

    // Abort mid-L1, then a clean run.
    @(negedge clk);
    x = {4{5'd15}}; w1 = {16{5'd15}}; w2 = {8{5'd15}}; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort out0", 32'(out0), 32'd0);
    check("abort out1", 32'(out1), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("abort no result", 32'(out_valid), 32'd0);
    run_op("rerun", {4{5'd15}}, {16{5'd15}}, {8{5'd15}},
           17'd54000, 17'd54000, 17'd54000, 17'd54000, 0);

    // Back-to-back: in_valid and out_ready held high.
    @(negedge clk);
    x = {4{5'd15}}; w1 = {16{5'd15}}; w2 = {8{5'd15}};
    in_valid = 1'b1; out_ready = 1'b1;
    last_cap = -1; n_cap = 0; n_res = 0;
    for (cyc = 0; cyc < 90; cyc++) begin
      if (in_ready) begin
        if (last_cap >= 0) check("ii gap", 32'(cyc - last_cap), 32'd26);
        last_cap = cyc;
        n_cap++;
      end
      if (out_valid) begin
        check("b2b out0", 32'(out0), 32'd54000);
        check("b2b out1", 32'(out1), 32'd54000);
        n_res++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b captures", 32'(n_cap), 32'd4);
    check("b2b results", 32'(n_res), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
